// File: rtl/serial_byte_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_byte_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_byte_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_byte_subtractor_if #(
  parameter int unsigned WIDTH = serial_byte_subtractor_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             bin;
  logic [WIDTH-1:0] out;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, in0, in1, bin,
    input  out, bout, busy, done
  );

  modport slave (
    input  start, in0, in1, bin,
    output out, bout, busy, done
  );

endinterface

// File: rtl/serial_byte_subtractor_full_subtractor.sv
// One-bit full subtractor: the per-step datapath of the serial subtractor.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_byte_subtractor.sv
// Bit-serial subtractor: out = in0 - in1 - bin, one bit per clock, LSB first.
module serial_byte_subtractor
  import serial_byte_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                      clk,
  input logic                      rst,
  serial_byte_subtractor_if.slave  bus
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               step_d;
  logic               step_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (step_d),
    .bout (step_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      out_q   <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Operands shift right while the difference fills in from the MSB end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    out_d   = out_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = bus.in0;
          b_d     = bus.in1;
          br_d    = bus.bin;
          diff_d  = '0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        br_d   = step_bout;
        diff_d = {step_d, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          out_d   = {step_d, diff_q[WIDTH-1:1]};
          bout_d  = step_bout;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.bout = bout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_byte_subtractor.sv
// Directed bench for serial_byte_subtractor with a cycle-level schedule model.
module tb_serial_byte_subtractor;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned W1    = WIDTH + 1;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  serial_byte_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_byte_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Unsigned subtraction with one extra bit: the top bit is the borrow.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             bi);
    return {1'b0, a} - {1'b0, b} - W1'(bi);
  endfunction

  // Schedule model: m_age counts edges since accept, 0 when idle.
  int               m_age = 0;
  logic [WIDTH:0]   m_pend = '0;
  logic [WIDTH-1:0] m_out = '0;
  logic             m_bout = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_age  <= 0;
      m_out  <= '0;
      m_bout <= 1'b0;
    end else if (m_age == 0) begin
      if (bus.start) begin
        m_age  <= 1;
        m_pend <= ref_sub(bus.in0, bus.in1, bus.bin);
      end
    end else if (m_age == int'(WIDTH)) begin
      m_age           <= WIDTH + 1;
      {m_bout, m_out} <= m_pend;
    end else if (m_age == int'(WIDTH) + 1) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic m_busy, m_done;
      m_busy = (m_age != 0);
      m_done = (m_age == int'(WIDTH) + 1);
      total++;
      if (bus.out !== m_out || bus.bout !== m_bout ||
          bus.busy !== m_busy || bus.done !== m_done) begin
        bad++;
        $display("FAIL model t=%0t got out=%h bout=%b busy=%b done=%b expected out=%h bout=%b busy=%b done=%b",
                 $time, bus.out, bus.bout, bus.busy, bus.done, m_out, m_bout, m_busy, m_done);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts edges from the accept edge until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] eo, input logic eb);
    int lat;
    wait_idle();
    bus.in0 = a; bus.in1 = b; bus.bin = bi; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    check({name, "_lat"}, 32'(lat), 32'd8);
    check({name, "_out"}, 32'(bus.out), 32'(eo));
    check({name, "_bout"}, 32'(bus.bout), 32'(eb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] oa [3];
    logic [7:0] ob [3];
    logic       obi[3];
    logic [7:0] eo [3];
    logic       eb [3];
    int ndone, last;

    // Reset with start held: start must be ignored while rst is high.
    rst = 1'b1; bus.start = 1'b1; bus.in0 = 8'h77; bus.in1 = 8'h11; bus.bin = 1'b0;
    repeat (2) @(posedge clk);
    #1; chk_en = 1'b1;
    check("reset_out",  32'(bus.out),  32'h0);
    check("reset_bout", 32'(bus.bout), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);

    // First edge after reset release accepts: 0x02 - 0x01.
    bus.in0 = 8'h02; bus.in1 = 8'h01; bus.bin = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("accept_after_rst", 32'(bus.busy), 32'h1);
    wait_done(lat);
    check("basic_lat",  32'(lat), 32'd8);
    check("basic_out",  32'(bus.out), 32'h01);
    check("basic_bout", 32'(bus.bout), 32'h0);

    run_op("neg",      8'h01, 8'h02, 1'b0, 8'hFF, 1'b1);
    run_op("pos",      8'h10, 8'h05, 1'b0, 8'h0B, 1'b0);
    run_op("ffff_b1",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("zero_b1",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_op("ff_zero",  8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    // Restart during RUN plus mid-run operand changes must be ignored.
    wait_idle();
    bus.in0 = 8'h08; bus.in1 = 8'h08; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.in0 = 8'h50; bus.in1 = 8'h01; bus.bin = 1'b1; bus.start = 1'b1;
    wait_done(lat);
    bus.start = 1'b0;
    check("ignore_lat",  32'(lat), 32'd6);
    check("ignore_out",  32'(bus.out), 32'h00);
    check("ignore_bout", 32'(bus.bout), 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    check("ignore_dropped", 32'(bus.busy), 32'h0);

    // Reset during RUN after a 0x0B result.
    run_op("pre_abort", 8'h10, 8'h05, 1'b0, 8'h0B, 1'b0);
    wait_idle();
    bus.in0 = 8'h33; bus.in1 = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out",  32'(bus.out),  32'h0);
    check("abort_bout", 32'(bus.bout), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    repeat (10) begin @(posedge clk); #1; end
    run_op("post_abort", 8'h10, 8'h05, 1'b0, 8'h0B, 1'b0);

    // start held high: accepts every WIDTH+2 cycles.
    oa[0] = 8'h05; ob[0] = 8'h03; obi[0] = 1'b0; eo[0] = 8'h02; eb[0] = 1'b0;
    oa[1] = 8'h03; ob[1] = 8'h05; obi[1] = 1'b0; eo[1] = 8'hFE; eb[1] = 1'b1;
    oa[2] = 8'hAA; ob[2] = 8'h55; obi[2] = 1'b1; eo[2] = 8'h54; eb[2] = 1'b0;
    wait_idle();
    bus.in0 = oa[0]; bus.in1 = ob[0]; bus.bin = obi[0]; bus.start = 1'b1;
    ndone = 0; last = 0;
    for (int c = 0; c < 60 && ndone < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        check("b2b_out",  32'(bus.out),  32'(eo[ndone]));
        check("b2b_bout", 32'(bus.bout), 32'(eb[ndone]));
        if (ndone > 0) check("b2b_spacing", 32'(c - last), 32'd10);
        last = c;
        ndone++;
        if (ndone < 3) begin
          bus.in0 = oa[ndone]; bus.in1 = ob[ndone]; bus.bin = obi[ndone];
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    repeat (12) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_subtractor.md
SERIAL_BYTE_SUBTRACTOR -- requirements
Module: serial_byte_subtractor

Interface
REQ-001 Parameter WIDTH, default 8; operand and result width in bits.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 in0  input  WIDTH  minuend.
REQ-006 in1  input  WIDTH  subtrahend.
REQ-007 bin  input  1  borrow-in; acts as the counterpart of the adder carry-in.
REQ-008 out  output  WIDTH  registered result, in0 - in1 - bin, modulo 2^WIDTH.
REQ-009 bout  output  1  registered borrow-out; 1 when in0 < in1 + bin (unsigned).
REQ-010 busy  output  1  high in RUN and DONE states.
REQ-011 done  output  1  one-cycle pulse that marks out/bout as newly valid.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN when start=1 at a clock edge.
- RUN->DONE after WIDTH bit-steps.
- DONE->IDLE unconditionally on the next edge.
REQ-013 On accept at edge E0, the block SHALL latch in0, in1 and bin into internal shift registers and clear the bit counter to 0.
REQ-014 The block SHALL process one bit per edge at edges E1..E_WIDTH, LSB first.
- Each step uses a full-subtractor: diff = a^b^br, br' = (~a&b) | (~(a^b)&br).
- The running borrow starts at the latched bin.
REQ-015 At edge E_WIDTH, the block SHALL load out with the assembled difference and bout with the final borrow, and the state SHALL become DONE.
REQ-016 done SHALL be 1 only while in DONE, i.e. exactly one cycle, from E_WIDTH to E_WIDTH+1.
REQ-017 Accept-to-done latency is WIDTH cycles; minimum start-to-start spacing is WIDTH+2 cycles.
REQ-018 out and bout SHALL hold the last completed result until the next completion; they SHALL NOT change during RUN.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing. in0, in1 and bin changes after E0 SHALL NOT affect the result in flight.
REQ-020 The bit counter SHALL be log2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.
REQ-021 Boundary: 0x00-0x00 with bin=1 SHALL give 0xFF, bout=1. 0xFF-0x00 with bin=0 SHALL give 0xFF, bout=0.

Reset
REQ-022 When rst=1 at an edge, the block SHALL set state=IDLE, out=0, bout=0, done=0, busy=0, and clear the counter and shift registers.
REQ-023 rst SHALL take priority over start and over an operation in progress. An aborted operation SHALL produce no done pulse and SHALL NOT update out/bout.
REQ-024 start asserted in the same cycle as rst SHALL be ignored. The first accept is possible at the first edge after rst deasserts.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-026 A single combinational sub-module full_subtractor (a, b, bin -> d, bout) SHALL implement the bit-step and SHALL be instantiated once.
REQ-027 The top level SHALL contain only the FSM, counter, shift registers and output registers; no multi-bit "-" operator SHALL be used.

Verification
REQ-028 in0=0x02, in1=0x01, bin=0, start pulse -> done pulse 8 cycles after accept; out=0x01, bout=0.
REQ-029 in0=0x01, in1=0x02, bin=0 -> out=0xFF, bout=1. In a separate operation, in0=0x10, in1=0x05, bin=0 -> out=0x0B, bout=0.
REQ-030 in0=0xFF, in1=0xFF, bin=1 -> out=0xFF, bout=1. In a separate operation, in0=0x00, in1=0x00, bin=1 -> out=0xFF, bout=1.
REQ-031 Start 0x08-0x08, then reassert start with 0x50-0x01 at cycle 3 of RUN and change operands mid-run -> single done, out=0x00, bout=0; second request dropped.
REQ-032 Assert rst at cycle 4 of RUN after a prior result of 0x0B -> no done pulse; out=0x00, bout=0, busy=0 next cycle. A new start then completes normally.
REQ-033 Back-to-back operations: start held high continuously -> accepts exactly every 10 cycles; each done is a single cycle; out is stable between done pulses.
